// File: rtl/fcu_seq.sv
// Flow-control sequencer: JAL/RET with a circular return-address stack,
// BRK exception pulse, interruptible WAIT countdown and NOP/default result.
module fcu_seq #(
  parameter int              WID     = 52,
  parameter int              AMSB    = 51,
  parameter int              RSDEPTH = 8,
  parameter logic [WID-1:0]  DEFVAL  = {13{4'hC}}
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [2:0]        fn_i,
  input  logic [WID-1:0]    a_i,
  input  logic [AMSB:0]     nextpc_i,
  input  logic [WID-1:0]    waitcnt_i,
  input  logic [3:0]        im_i,
  input  logic [3:0]        irq_lvl_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [WID-1:0]    bus_o,
  output logic              exc_o,
  output logic              mispredict_o,
  output logic [AMSB:0]     rs_top_o,
  output logic              rs_empty_o,
  output logic              rs_full_o
);

  localparam int PW = $clog2(RSDEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  localparam logic [2:0] FN_JAL  = 3'd1;
  localparam logic [2:0] FN_RET  = 3'd2;
  localparam logic [2:0] FN_BRK  = 3'd3;
  localparam logic [2:0] FN_WAIT = 3'd4;

  localparam logic [PW:0] D_FULL = (PW+1)'(RSDEPTH);
  localparam logic [PW:0] D_ONE  = (PW+1)'(1);

  logic [1:0]      state;
  logic [2:0]      fn_q;
  logic [WID-1:0]  a_q;
  logic [AMSB:0]   pc_q;
  logic [WID-1:0]  cnt;

  // Return stack: ptr is the next slot to write, depth saturates at RSDEPTH
  // so a push while full silently overwrites the oldest entry.
  logic [AMSB:0]   mem [RSDEPTH];
  logic [PW-1:0]   ptr;
  logic [PW:0]     depth;

  logic [PW-1:0]   ptr_m1;
  logic [PW-1:0]   ptr_m2;
  logic [AMSB:0]   pop_top;
  logic            abort;

  assign busy_o  = (state != S_IDLE);
  assign ptr_m1  = ptr - PW'(1);
  assign ptr_m2  = ptr - PW'(2);
  // Entry that becomes the top after a pop (zero when the pop empties the stack)
  assign pop_top = (depth > D_ONE) ? mem[ptr_m2] : '0;
  assign abort   = (irq_lvl_i > im_i);

  // Operand capture and stack storage; data only, no reset needed
  always_ff @(posedge clk_i) begin
    if (state == S_IDLE && start_i) begin
      a_q  <= a_i;
      pc_q <= nextpc_i;
    end
    if (state == S_EXEC && fn_q == FN_JAL) begin
      mem[ptr] <= pc_q;
    end
  end

  // Sequencer FSM, result/status registers and stack pointers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= S_IDLE;
      fn_q         <= '0;
      cnt          <= '0;
      bus_o        <= '0;
      done_o       <= 1'b0;
      exc_o        <= 1'b0;
      mispredict_o <= 1'b0;
      ptr          <= '0;
      depth        <= '0;
      rs_top_o     <= '0;
      rs_empty_o   <= 1'b1;
      rs_full_o    <= 1'b0;
    end else begin
      done_o       <= 1'b0;
      exc_o        <= 1'b0;
      mispredict_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            fn_q <= fn_i;
            if (fn_i == FN_WAIT && waitcnt_i != '0) begin
              cnt   <= waitcnt_i;
              state <= S_WAIT;
            end else begin
              state <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          done_o <= 1'b1;
          state  <= S_IDLE;
          case (fn_q)
            FN_JAL: begin
              bus_o      <= WID'(pc_q);
              ptr        <= ptr + PW'(1);
              if (depth != D_FULL) depth <= depth + D_ONE;
              rs_top_o   <= pc_q;
              rs_empty_o <= 1'b0;
              rs_full_o  <= (depth >= D_FULL - D_ONE);
            end
            FN_RET: begin
              bus_o        <= a_q;
              mispredict_o <= rs_empty_o || (rs_top_o != a_q[AMSB:0]);
              if (!rs_empty_o) begin
                ptr        <= ptr_m1;
                depth      <= depth - D_ONE;
                rs_top_o   <= pop_top;
                rs_empty_o <= (depth == D_ONE);
                rs_full_o  <= 1'b0;
              end
            end
            FN_BRK:  exc_o <= 1'b1;
            FN_WAIT: bus_o <= '0;
            default: bus_o <= DEFVAL;
          endcase
        end
        S_WAIT: begin
          // An interrupt above the mask wins over natural expiry and
          // reports the count still outstanding.
          if (abort || cnt == '0) begin
            done_o <= 1'b1;
            bus_o  <= cnt;
            cnt    <= '0;
            state  <= S_IDLE;
          end else begin
            cnt <= cnt - WID'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/fcu_seq.md
FCU_SEQ -- requirements
Module: fcu_seq

Interface
REQ-001 The block SHALL have parameter WID, default 52, data/result width.
REQ-002 The block SHALL have parameter AMSB, default 51, MSB of an address (address width AMSB+1 <= WID).
REQ-003 The block SHALL have parameter RSDEPTH, default 8, return-stack entries (power of two, >= 2).
REQ-004 The block SHALL have parameter DEFVAL, default {13{4'hC}}, result for NOP/undefined functions.
REQ-005 The block SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst_ni, input, 1, reset, asynchronous and active-low.
REQ-007 The block SHALL have port start_i, input, 1, operation request, accepted only while busy_o=0.
REQ-008 The block SHALL have port fn_i, input, 3, function: 0 NOP, 1 JAL, 2 RET, 3 BRK, 4 WAIT, 5-7 undefined.
REQ-009 The block SHALL have port a_i, input, WID, operand (return target for RET).
REQ-010 The block SHALL have port nextpc_i, input, AMSB+1, address of the following instruction.
REQ-011 The block SHALL have port waitcnt_i, input, WID, WAIT cycle count.
REQ-012 The block SHALL have ports im_i and irq_lvl_i, input, 4 each, interrupt mask and pending interrupt level.
REQ-013 The block SHALL have port busy_o, output, 1, high from the cycle after acceptance until done_o.
REQ-014 The block SHALL have port done_o, output, 1, one-cycle completion pulse.
REQ-015 The block SHALL have port bus_o, output, WID, registered result, valid with done_o and held until the next done_o.
REQ-016 The block SHALL have ports exc_o and mispredict_o, output, 1 each, pulses qualified by done_o.
REQ-017 The block SHALL have ports rs_top_o (AMSB+1), rs_empty_o and rs_full_o (1 each), outputs giving return-stack status.

Function
REQ-018 States SHALL be IDLE, EXEC and WAIT; start_i is sampled only in IDLE; inputs are captured at acceptance.
REQ-019 Every non-WAIT function, and WAIT with waitcnt_i=0, SHALL go IDLE->EXEC->IDLE, with done_o high in cycle N+1 for acceptance at edge N.
REQ-020 JAL SHALL set bus_o to nextpc_i zero-extended to WID and push nextpc_i onto the return stack.
REQ-021 A push while full SHALL overwrite the oldest entry (circular); rs_full_o SHALL stay 1 and the depth SHALL stay RSDEPTH.
REQ-022 RET SHALL set bus_o to a_i and pop; mispredict_o SHALL be 1 if the stack was empty or rs_top_o != a_i[AMSB:0].
REQ-023 RET on an empty stack SHALL leave the stack unchanged.
REQ-024 BRK SHALL pulse exc_o with done_o and leave bus_o unchanged.
REQ-025 NOP and fn_i 5-7 SHALL set bus_o to DEFVAL, with the stack unchanged.
REQ-026 WAIT with waitcnt_i=W>0 SHALL load a WID-bit counter with W, enter WAIT, and decrement once per cycle.
REQ-027 WAIT SHALL complete (done_o, ->IDLE) in the cycle the counter reaches 0, giving W+1 cycles from acceptance; bus_o SHALL then be 0.
REQ-028 In WAIT, irq_lvl_i > im_i (unsigned) SHALL abort immediately: done_o in that cycle, bus_o equal to the remaining count before decrement.
REQ-029 If abort and counter=0 coincide, the abort SHALL take precedence, with bus_o=0.
REQ-030 rs_empty_o, rs_full_o and rs_top_o SHALL be registered and reflect stack state after the last completed operation; rs_top_o SHALL be 0 when empty.
REQ-031 start_i asserted while busy_o=1 SHALL be ignored, with no queuing.

Reset
REQ-032 rst_ni low SHALL asynchronously force IDLE, bus_o=0, done_o=exc_o=mispredict_o=busy_o=0, stack empty (rs_empty_o=1, rs_full_o=0, rs_top_o=0), counter=0.
REQ-033 Reset during WAIT or EXEC SHALL abandon the operation without a done_o pulse; the first acceptance is possible at the first rising edge with rst_ni high.

Verification
REQ-034 Reset, then JAL with nextpc=0x100 -> done_o at N+1, bus_o=0x100, rs_top_o=0x100, rs_empty_o=0.
REQ-035 Push JAL 9 times (RSDEPTH=8, nextpc 1..9), then RET a_i=9..2 -> 8 RETs with no mispredict; a 9th RET with a_i=1 -> mispredict_o=1, rs_empty_o=1.
REQ-036 RET with a_i=0x200 against top=0x100 -> bus_o=0x200, mispredict_o=1, entry popped.
REQ-037 WAIT waitcnt=5, irq_lvl=0, im=0 -> done_o exactly 6 cycles after acceptance, bus_o=0; WAIT waitcnt=10 with irq_lvl=3 > im=2 raised 4 cycles in -> immediate done_o, bus_o=6.
REQ-038 BRK after JAL -> exc_o=1 with done_o, bus_o keeps the JAL value; fn=6 -> bus_o=DEFVAL; start_i held high during WAIT -> no extra operation.
REQ-039 rst_ni dropped mid-WAIT -> no done_o, all outputs at reset values asynchronously.
